rbc_ptr_rx: RTL and testbench

- Receiving end of a Gray-coded (RBC) pointer crossing into this clock domain, e.g. the remote FIFO write/read pointer.
- Synchronises the incoming Gray vector and decodes it to binary.
- Checks that every observed update is a legal single-bit Gray step; flags multi-bit jumps and re-baselines after them.
- Sits on the destination side of any Gray-coded pointer/counter link; its output feeds full/empty and occupancy logic.

---
 rtl/rbc_ptr_rx_pkg.sv | 14 +
 rtl/rbc_sync_chain.sv | 27 ++
 rtl/rbc_ptr_rx.sv | 156 +++++++++++++++
 tb/tb_rbc_ptr_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbc_ptr_rx_pkg.sv
// Shared constants for the Gray (RBC) pointer receiver: FSM encoding,
// baseline stability count and step-counter width.
package rbc_ptr_rx_pkg;

  localparam logic [1:0] ST_INIT   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_RESYNC = 2'd2;

  // Consecutive unchanged samples required before a pointer is trusted.
  localparam int unsigned STABLE_CYCLES = 2;

  localparam int unsigned STEP_CNT_W = 16;

endpackage

// File: rtl/rbc_sync_chain.sv
// Multi-flop synchroniser for a Gray-coded bus; reusable for any Gray crossing.
module rbc_sync_chain #(
  parameter int unsigned p_WIDTH       = 4,
  parameter int unsigned p_SYNC_STAGES = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic [p_WIDTH-1:0] iwv_d,
  output logic [p_WIDTH-1:0] owv_q
);

  logic [p_WIDTH-1:0] sync_q [p_SYNC_STAGES];

  // NOTE: every stage of this flop array is reset; a synchroniser must come up
  // with a known value, unlike a data RAM whose contents may stay undefined.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      for (int i = 0; i < int'(p_SYNC_STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= iwv_d;
      for (int i = 1; i < int'(p_SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign owv_q = sync_q[p_SYNC_STAGES-1];

endmodule

// File: rtl/rbc_ptr_rx.sv
// Receiver for a Gray-coded pointer from a foreign clock domain: synchronise,
// decode, police single-bit steps. Optional step counter: RBC_PTR_RX_STEP_CNT_EN.
module rbc_ptr_rx
  import rbc_ptr_rx_pkg::*;
#(
  parameter int unsigned p_WIDTH       = 4,
  parameter int unsigned p_SYNC_STAGES = 2
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic [p_WIDTH-1:0] iwv_rbc,
  input  logic               iw_clr,
  output logic [p_WIDTH-1:0] owv_bin,
  output logic               ow_ready,
  output logic               ow_step,
  output logic               ow_dir,
  output logic               ow_err,
  output logic               ow_err_sticky
`ifdef RBC_PTR_RX_STEP_CNT_EN
  ,
  output logic [STEP_CNT_W-1:0] owv_step_cnt
`endif
);

  localparam logic [1:0] STAB_LAST = 2'(STABLE_CYCLES - 1);

  logic [p_WIDTH-1:0] g_s, b_s, diff, delta;
  logic               no_chg, one_bit;

  logic [1:0]         state_q, state_d;
  logic [1:0]         stab_q, stab_d;
  logic [p_WIDTH-1:0] g_prev_q, g_prev_d;
  logic [p_WIDTH-1:0] bin_q, bin_d;
  logic               ready_q, ready_d;
  logic               step_q, step_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic               sticky_q, sticky_d;

  rbc_sync_chain #(
    .p_WIDTH       (p_WIDTH),
    .p_SYNC_STAGES (p_SYNC_STAGES)
  ) u_sync (
    .iw_clk   (iw_clk),
    .iw_rst_n (iw_rst_n),
    .iwv_d    (iwv_rbc),
    .owv_q    (g_s)
  );

  // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    for (int i = 0; i < int'(p_WIDTH); i++) b_s[i] = ^(g_s >> i);
  end

  assign diff    = g_s ^ g_prev_q;
  assign no_chg  = (diff == '0);
  assign one_bit = $onehot(diff);
  assign delta   = b_s - bin_q;

  // NOTE: every next-state variable gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    g_prev_d = g_prev_q;
    bin_d    = bin_q;
    ready_d  = ready_q;
    step_d   = 1'b0;
    dir_d    = dir_q;
    err_d    = 1'b0;
    case (state_q)
      ST_TRACK: begin
        if (one_bit) begin
          bin_d    = b_s;
          g_prev_d = g_s;
          step_d   = 1'b1;
          dir_d    = (delta == p_WIDTH'(1));
        end else if (!no_chg) begin
          err_d    = 1'b1;
          ready_d  = 1'b0;
          g_prev_d = g_s;
          stab_d   = '0;
          state_d  = ST_RESYNC;
        end
      end
      default: begin
        // INIT and RESYNC: follow the input until it has held still long enough.
        g_prev_d = g_s;
        if (!no_chg) begin
          stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
          stab_d  = '0;
          bin_d   = b_s;
          ready_d = 1'b1;
          state_d = ST_TRACK;
        end else begin
          stab_d = stab_q + 2'd1;
        end
      end
    endcase
    // A new error outranks a simultaneous clear.
    sticky_d = err_d | (sticky_q & ~iw_clr);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q  <= ST_INIT;
      stab_q   <= '0;
      g_prev_q <= '0;
      bin_q    <= '0;
      ready_q  <= 1'b0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      stab_q   <= stab_d;
      g_prev_q <= g_prev_d;
      bin_q    <= bin_d;
      ready_q  <= ready_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign owv_bin       = bin_q;
  assign ow_ready      = ready_q;
  assign ow_step       = step_q;
  assign ow_dir        = dir_q;
  assign ow_err        = err_q;
  assign ow_err_sticky = sticky_q;

`ifdef RBC_PTR_RX_STEP_CNT_EN
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over the count, but a step in the clearing cycle still counts.
  always_comb begin
    cnt_d = cnt_q;
    if (iw_clr)                       cnt_d = step_d ? STEP_CNT_W'(1) : '0;
    else if (step_d && cnt_q != '1)   cnt_d = cnt_q + STEP_CNT_W'(1);
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign owv_step_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rbc_ptr_rx.sv
// Self-checking bench for rbc_ptr_rx (W=4, 2 sync stages): directed table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_rbc_ptr_rx;

  localparam int W = 4;
  localparam int S = 2;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] rbc = '0;
  logic         clr = 1'b0;
  logic [W-1:0] bin;
  logic         ready, step, dir, err, sticky;
`ifdef RBC_PTR_RX_STEP_CNT_EN
  logic [15:0]  step_cnt;
`endif

  rbc_ptr_rx #(.p_WIDTH(W), .p_SYNC_STAGES(S)) dut (
    .iw_clk        (clk),
    .iw_rst_n      (rst_n),
    .iwv_rbc       (rbc),
    .iw_clr        (clr),
    .owv_bin       (bin),
    .ow_ready      (ready),
    .ow_step       (step),
    .ow_dir        (dir),
    .ow_err        (err),
    .ow_err_sticky (sticky)
`ifdef RBC_PTR_RX_STEP_CNT_EN
    ,
    .owv_step_cnt  (step_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] to_gray(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  function automatic int from_gray(input logic [W-1:0] g);
    int r = -1;
    for (int b = 0; b < M; b++) if (to_gray(b) == g) r = b;
    return r;
  endfunction

  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_gprev;
  int           m_bin, m_stable, m_cnt;
  bit           m_track, m_ready, m_step, m_dir, m_err, m_sticky;

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_pipe[i] = '0;
    m_gprev = '0; m_bin = 0; m_stable = 0; m_cnt = 0;
    m_track = 0; m_ready = 0; m_step = 0; m_dir = 0; m_err = 0; m_sticky = 0;
  endtask

  task automatic model_step();
    logic [W-1:0] gs;
    int d, bs;
    gs = m_pipe[S-1];
    for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = rbc;
    d  = $countones(gs ^ m_gprev);
    bs = from_gray(gs);
    m_step = 0;
    m_err  = 0;
    if (m_track) begin
      if (d == 1) begin
        m_dir   = (((bs - m_bin) % M + M) % M) == 1;
        m_bin   = bs;
        m_gprev = gs;
        m_step  = 1;
      end else if (d >= 2) begin
        m_err    = 1;
        m_ready  = 0;
        m_gprev  = gs;
        m_track  = 0;
        m_stable = 0;
      end
    end else begin
      m_stable = (d == 0) ? m_stable + 1 : 0;
      m_gprev  = gs;
      if (m_stable == 2) begin
        m_track  = 1;
        m_ready  = 1;
        m_bin    = bs;
        m_stable = 0;
      end
    end
    if (m_err)    m_sticky = 1;
    else if (clr) m_sticky = 0;
    if (clr)                         m_cnt = m_step ? 1 : 0;
    else if (m_step && m_cnt < 65535) m_cnt++;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic compare_all();
    check("rnd_bin",    32'(bin),    32'(m_bin));
    check("rnd_ready",  32'(ready),  32'(m_ready));
    check("rnd_step",   32'(step),   32'(m_step));
    check("rnd_dir",    32'(dir),    32'(m_dir));
    check("rnd_err",    32'(err),    32'(m_err));
    check("rnd_sticky", 32'(sticky), 32'(m_sticky));
`ifdef RBC_PTR_RX_STEP_CNT_EN
    check("rnd_cnt",    32'(step_cnt), 32'(m_cnt));
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [W-1:0] rbc;
    logic [W-1:0] bin;
    logic         ready, step, dir, err, sticky;
    logic [W-1:0] bin_end;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [W-1:0] prev_bin;
    int cur;

    tbl[0]  = '{4'b0001, 4'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1};
    tbl[1]  = '{4'b0011, 4'd2,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
    tbl[2]  = '{4'b0010, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3};
    tbl[3]  = '{4'b0110, 4'd4,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4};
    tbl[4]  = '{4'b0111, 4'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5};
    tbl[5]  = '{4'b0101, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6};
    tbl[6]  = '{4'b0111, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5};
    tbl[7]  = '{4'b0101, 4'd6,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6};
    tbl[8]  = '{4'b1101, 4'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd9};
    tbl[9]  = '{4'b1001, 4'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd14};
    tbl[10] = '{4'b1000, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd15};
    tbl[11] = '{4'b0000, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[12] = '{4'b1000, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15};
    tbl[13] = '{4'b0000, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[14] = '{4'b0011, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2};
    tbl[15] = '{4'b0010, 4'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3};

    model_reset();

    // Reset state and INIT baseline with input held at zero.
    #12;
    check("rst_bin",    32'(bin),    0);
    check("rst_ready",  32'(ready),  0);
    check("rst_step",   32'(step),   0);
    check("rst_err",    32'(err),    0);
    check("rst_sticky", 32'(sticky), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle();
    check("init_ready_1", 32'(ready), 0);
    cycle();
    check("init_ready_2", 32'(ready), 1);
    check("init_bin",     32'(bin),   0);
    check("init_step",    32'(step),  0);
    check("init_err",     32'(err),   0);
    repeat (2) cycle();

    // Directed table: latency, pulse width, direction, wrap, jump + resync.
    prev_bin = '0;
    for (int k = 0; k < 16; k++) begin
      rbc = tbl[k].rbc;
      cycle(); cycle();
      check("tbl_early_step", 32'(step), 0);
      check("tbl_early_bin",  32'(bin),  32'(prev_bin));
      cycle();
      check("tbl_bin",    32'(bin),    32'(tbl[k].bin));
      check("tbl_ready",  32'(ready),  32'(tbl[k].ready));
      check("tbl_step",   32'(step),   32'(tbl[k].step));
      check("tbl_dir",    32'(dir),    32'(tbl[k].dir));
      check("tbl_err",    32'(err),    32'(tbl[k].err));
      check("tbl_sticky", 32'(sticky), 32'(tbl[k].sticky));
      cycle();
      check("tbl_step_off", 32'(step), 0);
      check("tbl_err_off",  32'(err),  0);
      repeat (4) cycle();
      check("tbl_bin_end",   32'(bin),   32'(tbl[k].bin_end));
      check("tbl_ready_end", 32'(ready), 1);
      prev_bin = tbl[k].bin_end;
    end

    // Clear coinciding with a second illegal jump: set wins.
    rbc = 4'b1100;
    cycle(); cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_jump_err",    32'(err),    1);
    check("clr_jump_sticky", 32'(sticky), 1);
    check("clr_jump_step",   32'(step),   0);
    repeat (5) cycle();
    check("clr_jump_ready",  32'(ready),  1);
    check("clr_jump_bin",    32'(bin),    8);
    check("clr_jump_hold",   32'(sticky), 1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_alone_sticky", 32'(sticky), 0);

    // Randomized traffic against the model.
    cur = 8;
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(99));
      if (sel < 50)      cur = cur;
      else if (sel < 70) cur = (cur + 1) % M;
      else if (sel < 85) cur = (cur + M - 1) % M;
      else               cur = int'($urandom_range(M - 1));
      rbc = to_gray(cur);
      clr = ($urandom_range(19) == 0);
      cycle();
      compare_all();
    end
    clr = 1'b0;
    repeat (6) cycle();
    compare_all();

    // Reset asserted while a step pulse is high.
    cur = (cur + 1) % M;
    rbc = to_gray(cur);
    repeat (3) cycle();
    check("mid_step_high", 32'(step), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bin",    32'(bin),    0);
    check("mid_rst_ready",  32'(ready),  0);
    check("mid_rst_step",   32'(step),   0);
    check("mid_rst_dir",    32'(dir),    0);
    check("mid_rst_err",    32'(err),    0);
    check("mid_rst_sticky", 32'(sticky), 0);
`ifdef RBC_PTR_RX_STEP_CNT_EN
    check("mid_rst_cnt",    32'(step_cnt), 0);
`endif
    rbc = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    check("post_rst_ready", 32'(ready), 1);

    // Twenty consecutive up-steps, then clear.
    for (int i = 1; i <= 20; i++) begin
      rbc = to_gray(i % M);
      cycle();
    end
    repeat (4) cycle();
    check("up20_bin", 32'(bin), 4);
    check("up20_dir", 32'(dir), 1);
`ifdef RBC_PTR_RX_STEP_CNT_EN
    check("up20_cnt", 32'(step_cnt), 20);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("cnt_cleared", 32'(step_cnt), 0);
    rbc = to_gray(5);
    cycle(); cycle();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("cnt_clr_step_pulse", 32'(step), 1);
    check("cnt_clr_step",       32'(step_cnt), 1);
`endif
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
